// File: rtl/ibex_lockstep_ctrl.sv
// Lockstep shadow-core sequencer: delays reset/fetch release of the shadow core and
// turns raw compare mismatches into minor and sticky major alerts.
module ibex_lockstep_ctrl #(
    parameter int unsigned LockstepOffset = 2,
    parameter int unsigned MismatchThresh = 1,
    parameter int unsigned CntWidth       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fetch_enable_i,
    input  logic                mismatch_i,
    input  logic                bus_mismatch_i,
    output logic                shadow_rst_o,
    output logic                shadow_fetch_enable_o,
    output logic                compare_en_o,
    output logic                alert_minor_o,
    output logic                alert_major_internal_o,
    output logic                alert_major_bus_o,
    output logic [1:0]          state_o,
    output logic [CntWidth-1:0] mismatch_cnt_o
);

    if (LockstepOffset < 1 || LockstepOffset > 15) begin : g_bad_offset
        $error("LockstepOffset must be in 1..15");
    end
    if (MismatchThresh < 1 || MismatchThresh > 15) begin : g_bad_thresh
        $error("MismatchThresh must be in 1..15");
    end
    if (CntWidth < 1) begin : g_bad_cnt_width
        $error("CntWidth must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWarmup = 2'd1,
        StActive = 2'd2,
        StFault  = 2'd3
    } state_e;

    localparam logic [3:0] WarmLast = 4'(LockstepOffset - 1);
    localparam logic [4:0] Thresh   = 5'(MismatchThresh);

    state_e                  r_state, w_state_d;
    logic [3:0]              r_warm_cnt, w_warm_cnt_d;
    logic [3:0]              r_consec, w_consec_d;
    logic [CntWidth-1:0]     r_cnt, w_cnt_d;
    logic                    r_minor, w_minor_d;
    logic                    r_alert_int, w_alert_int_d;
    logic                    r_alert_bus, w_alert_bus_d;
    logic [LockstepOffset-1:0] r_delay;

    logic [4:0]          w_consec_inc;
    logic [3:0]          w_consec_sat;
    logic [CntWidth-1:0] w_cnt_sat;
    logic                w_thresh_hit;
    logic                w_burst_open;

    assign w_consec_inc = {1'b0, r_consec} + 5'd1;
    assign w_consec_sat = (r_consec == 4'hF) ? 4'hF : w_consec_inc[3:0];
    assign w_cnt_sat    = (&r_cnt) ? r_cnt : r_cnt + CntWidth'(1);
    assign w_thresh_hit = mismatch_i && (w_consec_inc >= Thresh);
    // A burst is still open if it continues this cycle or ran up to the previous one.
    assign w_burst_open = mismatch_i || (r_consec != 4'd0);

    always_comb begin
        w_state_d     = r_state;
        w_warm_cnt_d  = r_warm_cnt;
        w_consec_d    = r_consec;
        w_cnt_d       = r_cnt;
        w_minor_d     = 1'b0;
        w_alert_int_d = r_alert_int;
        w_alert_bus_d = r_alert_bus;
        unique case (r_state)
            StIdle: begin
                if (fetch_enable_i) begin
                    w_state_d    = StWarmup;
                    w_warm_cnt_d = 4'd0;
                end
            end
            StWarmup: begin
                if (r_warm_cnt == WarmLast) begin
                    w_state_d = StActive;
                end else begin
                    w_warm_cnt_d = r_warm_cnt + 4'd1;
                end
            end
            StActive: begin
                if (bus_mismatch_i || w_thresh_hit) begin
                    w_state_d     = StFault;
                    w_alert_bus_d = r_alert_bus | bus_mismatch_i;
                    w_alert_int_d = r_alert_int | w_thresh_hit;
                    w_consec_d    = mismatch_i ? w_consec_sat : 4'd0;
                    if (w_burst_open) begin
                        w_cnt_d = w_cnt_sat;
                    end
                end else if (mismatch_i) begin
                    w_consec_d = w_consec_sat;
                end else if (r_consec != 4'd0) begin
                    w_minor_d  = 1'b1;
                    w_cnt_d    = w_cnt_sat;
                    w_consec_d = 4'd0;
                end
            end
            StFault: begin
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_warm_cnt  <= 4'd0;
            r_consec    <= 4'd0;
            r_cnt       <= '0;
            r_minor     <= 1'b0;
            r_alert_int <= 1'b0;
            r_alert_bus <= 1'b0;
            r_delay     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_warm_cnt  <= w_warm_cnt_d;
            r_consec    <= w_consec_d;
            r_cnt       <= w_cnt_d;
            r_minor     <= w_minor_d;
            r_alert_int <= w_alert_int_d;
            r_alert_bus <= w_alert_bus_d;
            // Truncating cast drops the oldest bit, so this works for a depth of 1 too.
            if (r_state != StIdle) begin
                r_delay <= LockstepOffset'({r_delay, fetch_enable_i});
            end
        end
    end

    assign shadow_rst_o           = (r_state == StIdle);
    assign shadow_fetch_enable_o  = r_delay[LockstepOffset-1];
    assign compare_en_o           = (r_state == StActive);
    assign alert_minor_o          = r_minor;
    assign alert_major_internal_o = r_alert_int;
    assign alert_major_bus_o      = r_alert_bus;
    assign state_o                = r_state;
    assign mismatch_cnt_o         = r_cnt;

endmodule

// File: tb/tb_ibex_lockstep_ctrl.sv
// Bench for ibex_lockstep_ctrl: two instances with different offsets/thresholds share
// the stimulus; a timeline-based reference model feeds per-instance scoreboards.
module tb_ibex_lockstep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, fe = 1'b0, mm = 1'b0, bm = 1'b0;

    logic       a_srst, a_sfe, a_cen, a_minor, a_aint, a_abus;
    logic [1:0] a_st;
    logic [3:0] a_cnt;
    logic       b_srst, b_sfe, b_cen, b_minor, b_aint, b_abus;
    logic [1:0] b_st;
    logic [3:0] b_cnt;

    ibex_lockstep_ctrl #(.LockstepOffset(2), .MismatchThresh(3), .CntWidth(4)) u_dut_a (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .fetch_enable_i         (fe),
        .mismatch_i             (mm),
        .bus_mismatch_i         (bm),
        .shadow_rst_o           (a_srst),
        .shadow_fetch_enable_o  (a_sfe),
        .compare_en_o           (a_cen),
        .alert_minor_o          (a_minor),
        .alert_major_internal_o (a_aint),
        .alert_major_bus_o      (a_abus),
        .state_o                (a_st),
        .mismatch_cnt_o         (a_cnt)
    );

    ibex_lockstep_ctrl #(.LockstepOffset(1), .MismatchThresh(1), .CntWidth(4)) u_dut_b (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .fetch_enable_i         (fe),
        .mismatch_i             (mm),
        .bus_mismatch_i         (bm),
        .shadow_rst_o           (b_srst),
        .shadow_fetch_enable_o  (b_sfe),
        .compare_en_o           (b_cen),
        .alert_minor_o          (b_minor),
        .alert_major_internal_o (b_aint),
        .alert_major_bus_o      (b_abus),
        .state_o                (b_st),
        .mismatch_cnt_o         (b_cnt)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       srst;
        logic       sfe;
        logic       cen;
        logic       minor;
        logic       aint;
        logic       abus;
        logic [3:0] cnt;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle    = 0;

    // Reference model: time since fetch release, fault flag and burst length.
    int m_off[2] = '{2, 1};
    int m_th[2]  = '{3, 1};
    bit m_started[2], m_fault[2], m_minor[2], m_aint[2], m_abus[2];
    int m_t[2], m_run[2], m_cnt[2], m_n0[2];
    bit fe_log[$];

    task automatic model_edge(input int k, input bit r, input bit f, input bit m, input bit b);
        int  run_new;
        bit  hit;
        m_minor[k] = 1'b0;
        if (r) begin
            m_started[k] = 0; m_fault[k] = 0; m_aint[k] = 0; m_abus[k] = 0;
            m_t[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
        end else if (!m_started[k]) begin
            if (f) begin
                m_started[k] = 1;
                m_t[k]       = 0;
                m_n0[k]      = fe_log.size() - 1;
            end
        end else begin
            if (m_t[k] >= m_off[k] && !m_fault[k]) begin
                run_new = m ? m_run[k] + 1 : 0;
                hit     = m && (run_new >= m_th[k]);
                if (b || hit) begin
                    m_fault[k] = 1;
                    if (b) m_abus[k] = 1;
                    if (hit) m_aint[k] = 1;
                    if (m || m_run[k] > 0) m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
                end else if (!m && m_run[k] > 0) begin
                    m_minor[k] = 1;
                    m_cnt[k]   = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
                end
                m_run[k] = run_new;
            end
            m_t[k]++;
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        bit   act;
        act     = m_started[k] && (m_t[k] >= m_off[k]);
        o.st    = !m_started[k] ? 2'd0 : m_fault[k] ? 2'd3 : act ? 2'd2 : 2'd1;
        o.srst  = !m_started[k];
        o.sfe   = act ? fe_log[m_n0[k] + m_t[k] - m_off[k] + 1] : 1'b0;
        o.cen   = (o.st == 2'd2);
        o.minor = m_minor[k];
        o.aint  = m_aint[k];
        o.abus  = m_abus[k];
        o.cnt   = 4'(m_cnt[k]);
        return o;
    endfunction

    task automatic drive(input bit r, input bit f, input bit m, input bit b);
        @(negedge clk);
        rst = r; fe = f; mm = m; bm = b;
        fe_log.push_back(f);
        for (int k = 0; k < 2; k++) model_edge(k, r, f, m, b);
        q_a.push_back(model_obs(0));
        q_b.push_back(model_obs(1));
    endtask

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got st=%0d srst=%0b sfe=%0b cen=%0b minor=%0b aint=%0b abus=%0b cnt=%0d, expected st=%0d srst=%0b sfe=%0b cen=%0b minor=%0b aint=%0b abus=%0b cnt=%0d",
                     name, cycle, got.st, got.srst, got.sfe, got.cen, got.minor, got.aint,
                     got.abus, got.cnt, exp.st, exp.srst, exp.sfe, exp.cen, exp.minor,
                     exp.aint, exp.abus, exp.cnt);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
    always @(posedge clk) begin
        #1;
        cycle++;
        if (q_a.size() > 0) compare("dut_a", {a_st, a_srst, a_sfe, a_cen, a_minor, a_aint, a_abus, a_cnt}, q_a.pop_front());
        if (q_b.size() > 0) compare("dut_b", {b_st, b_srst, b_sfe, b_cen, b_minor, b_aint, b_abus, b_cnt}, q_b.pop_front());
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic restart();
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        // Release with mismatches during warm-up, then quiet active cycles.
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        repeat (3) drive(0, 1, 0, 0);
        // Two-cycle burst below threshold, then a threshold burst.
        drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
        drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 0);
        // Bus and core mismatch together, alerts must hold.
        restart();
        drive(0, 1, 1, 1);
        repeat (100) drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        // Counter saturation, then reset from FAULT.
        restart();
        repeat (20) begin
            drive(0, 1, 1, 0);
            drive(0, 1, 0, 0);
        end
        drive(0, 1, 0, 1);
        repeat (3) drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        // Randomized episodes.
        repeat (40) begin
            int len;
            bit f;
            repeat ($urandom_range(1, 2)) drive(1, 0, 0, 0);
            repeat ($urandom_range(0, 3)) drive(0, 0, 0, 0);
            len = $urandom_range(10, 40);
            f   = 1'b1;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) f = ~f;
                drive(0, f, ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
            end
        end
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
